// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared FSM state encoding and default operand width for the serial comparator
package serial_cmp_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/serial_cmp8_if.sv
// serial_cmp8_if: start/operand/cascade inputs and busy/done/EQ/GT results of one comparator stage
// master drives start, A, B, eq, gt; slave (the comparator) drives busy, done, EQ, GT.
interface serial_cmp8_if import serial_cmp_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             eq;
  logic             gt;
  logic             busy;
  logic             done;
  logic             EQ;
  logic             GT;
  modport master (output start, A, B, eq, gt, input busy, done, EQ, GT);
  modport slave (input start, A, B, eq, gt, output busy, done, EQ, GT);
endinterface

// File: rtl/serial_cmp8_cmp1bit.sv
// cmp1bit: single-bit decision for the serial compare
// a, b: the bit pair under test; differ: bits are unequal; a_gt: a is 1 and b is 0.
module cmp1bit (
  input  logic a,
  input  logic b,
  output logic differ,
  output logic a_gt
);
  assign differ = a ^ b;
  assign a_gt   = a & ~b;
endmodule

// File: rtl/serial_cmp8.sv
// serial_cmp8: MSB-first bit-serial unsigned magnitude comparator with cascade inputs
// clk/rst: clock and synchronous active-high reset; bus: start/A/B/eq/gt in, busy/done/EQ/GT out.
// A start in IDLE captures the operands; SHIFT walks one bit per cycle and stops at the first
// differing bit; DONE pulses done for one cycle while EQ/GT hold the registered result.
module serial_cmp8 import serial_cmp_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic            clk,
  input logic            rst,
  serial_cmp8_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ceq_q, ceq_d, cgt_q, cgt_d;
  logic             eq_q, eq_d, gt_q, gt_d;
  logic             differ, a_gt;
  cmp1bit u_bit (.a(a_q[cnt_q]), .b(b_q[cnt_q]), .differ(differ), .a_gt(a_gt));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ceq_d   = ceq_q;
    cgt_d   = cgt_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d     = bus.A;
        b_d     = bus.B;
        ceq_d   = bus.eq;
        cgt_d   = bus.gt;
        cnt_d   = CNT_MAX;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (differ || cnt_q == '0) begin
          eq_d    = differ ? 1'b0 : ceq_q;
          gt_d    = differ ? a_gt : cgt_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ceq_q   <= 1'b0;
      cgt_q   <= 1'b0;
      cnt_q   <= CNT_MAX;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ceq_q   <= ceq_d;
      cgt_q   <= cgt_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end
  assign bus.busy = state_q == SHIFT;
  assign bus.done = state_q == DONE;
  assign bus.EQ   = eq_q;
  assign bus.GT   = gt_q;
endmodule

// File: tb/tb_serial_cmp8.sv
// tb_serial_cmp8: directed and random compares against a bit-scan model with a result scoreboard
module tb_serial_cmp8;
  localparam int W = 8;
  typedef struct {
    logic eq;
    logic gt;
    int   cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sc[$];
  exp_t last;
  exp_t me;
  serial_cmp8_if #(.WIDTH(W)) bus ();
  serial_cmp8 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic e, input logic g, input int t);
    exp_t r;
    logic found;
    r.eq  = e;
    r.gt  = g;
    r.cyc = t + W;
    found = 1'b0;
    for (int k = W - 1; k >= 0; k--)
      if (!found && a[k] != b[k]) begin
        found = 1'b1;
        r.eq  = 1'b0;
        r.gt  = a[k];
        r.cyc = t + W - k;
      end
    return r;
  endfunction
  always @(negedge clk)
    if (!rst && bus.done === 1'b1) begin
      if (sc.size() == 0) chk("spurious_done", bus.done, 1'b0);
      else begin
        me = sc.pop_front();
        chk("EQ", bus.EQ, me.eq);
        chk("GT", bus.GT, me.gt);
        chk("latency", cyc, me.cyc);
        last = me;
      end
    end
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic e, input logic g);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.eq = e;
    bus.gt = g;
    sc.push_back(model(a, b, e, g, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic finish_cmp();
    int n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      chk("busy_shift", bus.busy, 1'b1);
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("timeout", bus.done, 1'b1);
    else chk("busy_in_done", bus.busy, 1'b0);
    @(negedge clk);
    chk("idle_busy", bus.busy, 1'b0);
    chk("done_one_cycle", bus.done, 1'b0);
    chk("hold_EQ", bus.EQ, last.eq);
    chk("hold_GT", bus.GT, last.gt);
  endtask
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic e, input logic g);
    launch(a, b, e, g);
    finish_cmp();
  endtask
  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.eq = 1'b0;
    bus.gt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_EQ", bus.EQ, 1'b0);
    chk("rst_GT", bus.GT, 1'b0);
    rst = 1'b0;
    run(8'h2E, 8'h2E, 1'b1, 1'b0);
    run(8'h2E, 8'h2F, 1'b1, 1'b0);
    run(8'h2F, 8'h2E, 1'b1, 1'b0);
    run(8'hAF, 8'h2F, 1'b1, 1'b0);
    run(8'h00, 8'h00, 1'b0, 1'b1);
    run(8'h5A, 8'h5A, 1'b1, 1'b1);
    run(8'h01, 8'h00, 1'b0, 1'b0);
    run(8'hFF, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      run(8'($urandom), 8'($urandom_range(0, 1) != 0 ? 8'h3C : 8'($urandom)), 1'($urandom), 1'($urandom));
    launch(8'h2E, 8'h2E, 1'b1, 1'b0);
    bus.A = 8'hFF;
    bus.B = 8'h00;
    bus.eq = 1'b0;
    bus.gt = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'h00;
    bus.B = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_ignored_busy", bus.busy, 1'b1);
    begin
      int n = 0;
      while (bus.done !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n == 20) chk("timeout_restart", bus.done, 1'b1);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_in_done_ignored", bus.busy, 1'b0);
    @(negedge clk);
    chk("still_idle", bus.busy, 1'b0);
    run(8'hC3, 8'hC1, 1'b0, 1'b0);
    launch(8'h11, 8'h11, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("busy_before_abort", bus.busy, 1'b1);
    rst = 1'b1;
    sc.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_EQ", bus.EQ, 1'b0);
    chk("abort_GT", bus.GT, 1'b0);
    repeat (12) @(negedge clk);
    chk("abort_no_done", bus.done, 1'b0);
    last.eq = 1'b0;
    last.gt = 1'b0;
    run(8'h80, 8'h7F, 1'b0, 1'b0);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.A = 8'h01;
    bus.B = 8'h02;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_over_start_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("rst_over_start_idle", bus.busy, 1'b0);
    chk("rst_over_start_EQ", bus.EQ, 1'b0);
    chk("rst_over_start_GT", bus.GT, 1'b0);
    last.eq = 1'b0;
    last.gt = 1'b0;
    run(8'h2E, 8'h2E, 1'b1, 1'b0);
    chk("scoreboard_empty", 32'(sc.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_cmp8.md
SERIAL_CMP8 -- requirements
Module: serial_cmp8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to capture operands and begin a compare.
REQ-005 SHALL have port A  input  WIDTH  operand A, sampled only on an accepted start.
REQ-006 SHALL have port B  input  WIDTH  operand B, sampled only on an accepted start.
REQ-007 SHALL have port eq  input  1  cascade equal-in from the less-significant stage, sampled with A/B.
REQ-008 SHALL have port gt  input  1  cascade greater-in from the less-significant stage, sampled with A/B.
REQ-009 SHALL have port busy  output  1  high while a compare is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-011 SHALL have port EQ  output  1  registered result: A equals B, combined with cascade.
REQ-012 SHALL have port GT  output  1  registered result: A greater than B, combined with cascade.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 at edge T SHALL capture A, B, eq, gt and a bit index cnt=WIDTH-1; enter SHIFT at T+1.
REQ-015 start SHALL be accepted only in IDLE; start in SHIFT or DONE SHALL be ignored with no effect on captured data.
REQ-016 SHIFT: each cycle SHALL compare captured bit A[cnt] against B[cnt], MSB first, unsigned.
REQ-017 SHIFT, bits differ: next edge SHALL set EQ=0, GT=A[cnt] and enter DONE (early termination).
REQ-018 SHIFT, bits equal, cnt>0: SHALL decrement cnt and remain in SHIFT.
REQ-019 SHIFT, bits equal, cnt==0: next edge SHALL set EQ=captured eq, GT=captured gt and enter DONE.
REQ-020 DONE: done=1 for exactly one cycle; next edge SHALL return to IDLE unconditionally.
REQ-021 busy SHALL be 1 exactly in SHIFT; 0 in IDLE and DONE.
REQ-022 Latency: first differing bit k gives done high in cycle T+1+(WIDTH-k); all bits equal gives T+WIDTH+1.
REQ-023 EQ/GT SHALL hold their last value from DONE through IDLE until the next result overwrites them; no change during SHIFT.
REQ-024 Changes on A/B/eq/gt after capture SHALL not affect the result in progress.
REQ-025 Cascade inputs SHALL pass through unmodified when operands are equal, including illegal eq=1,gt=1.

Reset
REQ-026 rst=1 at any edge SHALL force state IDLE, busy=0, done=0, EQ=0, GT=0, cnt=WIDTH-1.
REQ-027 rst asserted mid-SHIFT SHALL abort the compare; no done pulse SHALL follow.
REQ-028 rst SHALL take priority over start in the same cycle.

Structure
REQ-029 Shared package serial_cmp_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default width constant.
REQ-030 One sub-module cmp1bit (combinational: a, b -> differ, a_gt) SHALL be instantiated for the per-bit decision; all other logic lives in serial_cmp8.
REQ-031 Counter cnt SHALL be $clog2(WIDTH) bits wide; no combinational path from start to done.

Verification (WIDTH=8)
REQ-032 A=8'h2E, B=8'h2E, eq=1, gt=0, start at T -> done at T+9, EQ=1, GT=0; busy high T+1..T+8.
REQ-033 A=8'h2E, B=8'h2F -> done at T+9, EQ=0, GT=0. Swapped, A=8'h2F, B=8'h2E -> EQ=0, GT=1.
REQ-034 A=8'hAF, B=8'h2F -> early exit, done at T+2, EQ=0, GT=1; busy high only in T+1.
REQ-035 A=B=8'h00, eq=0, gt=1 -> done at T+9, EQ=0, GT=1 (cascade pass-through).
REQ-036 Start at T, rst=1 at T+4 -> busy=0 from T+5, no done pulse, EQ=GT=0. Next start completes normally.
REQ-037 Start re-asserted at T+3 with different A/B -> ignored; first result unaffected; start in DONE cycle ignored.
